// File: rtl/fetch_decode_skid.sv
// fetch_decode_skid: DEPTH-entry FIFO buffering fetch packets for decode; registered-only f_ready.
// Optional FD_SKID_NOP_EN: present a NOP (addi x0,x0,0) on d_* while no entry is valid.
module fetch_decode_skid #(
    parameter int DEPTH  = 2,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic [WORD_W-1:0] f_pc,
    input  logic [WORD_W-1:0] f_inst,
    input  logic              f_branch_predict,
    input  logic [WORD_W-1:0] f_branch_target,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [WORD_W-1:0] d_pc,
    output logic [WORD_W-1:0] d_inst,
    output logic              d_branch_predict,
    output logic [WORD_W-1:0] d_branch_target
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
        logic              bp;
        logic [WORD_W-1:0] bt;
    } entry_t;
    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;
    assign f_ready = count < CW'(DEPTH);
    assign d_valid = count != '0;
    assign push    = en & f_valid & f_ready & ~flush;
    assign pop     = en & d_valid & d_ready & ~flush;
    assign head    = mem[rd_ptr];
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: f_pc, inst: f_inst, bp: f_branch_predict, bt: f_branch_target};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
`ifdef FD_SKID_NOP_EN
    assign d_pc             = d_valid ? head.pc : '0;
    assign d_inst           = d_valid ? head.inst : WORD_W'(32'h0000_0013);
    assign d_branch_predict = d_valid & head.bp;
    assign d_branch_target  = d_valid ? head.bt : '0;
`else
    assign d_pc             = head.pc;
    assign d_inst           = head.inst;
    assign d_branch_predict = head.bp;
    assign d_branch_target  = head.bt;
`endif
endmodule

// File: tb/tb_fetch_decode_skid.sv
// tb_fetch_decode_skid: table-driven directed vectors for fetch_decode_skid (DEPTH=2).
module tb_fetch_decode_skid;
    logic        CLK = 1'b0, nRST = 1'b0;
    logic        en = 1'b0, flush = 1'b0, f_valid = 1'b0, d_ready = 1'b0;
    logic        f_ready, d_valid, f_branch_predict = 1'b0, d_branch_predict;
    logic [31:0] f_pc = '0, f_inst = '0, f_branch_target = '0;
    logic [31:0] d_pc, d_inst, d_branch_target;
    int          errors = 0, checks = 0;

    fetch_decode_skid #(.DEPTH(2), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_inst(f_inst),
        .f_branch_predict(f_branch_predict), .f_branch_target(f_branch_target),
        .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_inst(d_inst),
        .d_branch_predict(d_branch_predict), .d_branch_target(d_branch_target)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        en, fl, fv, dr;
        logic [31:0] pc;
        logic        dv, fr;
        logic [31:0] dpc;
    } vec_t;
    vec_t tv[$];

    function automatic logic [31:0] inst_of(logic [31:0] pc);
        return {pc[19:0] + 20'h400, 12'h093};
    endfunction

    task automatic add(input logic e, fl, fv, dr, input logic [31:0] pc,
                       input logic dv, fr, input logic [31:0] dpc);
        tv.push_back('{e, fl, fv, dr, pc, dv, fr, dpc});
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected d_* for a given valid flag and head pc, honouring the NOP build.
    task automatic chk_out(input string tag, input logic dv, fr, input logic [31:0] dpc);
        logic [31:0] epc, einst, ebt;
        logic        ebp;
        epc = dpc; einst = inst_of(dpc); ebt = dpc + 32'h1000; ebp = dpc[2];
`ifdef FD_SKID_NOP_EN
        if (!dv) begin epc = '0; einst = 32'h13; ebt = '0; ebp = 1'b0; end
`endif
        chk({tag, ".d_valid"}, 32'(d_valid), 32'(dv));
        chk({tag, ".f_ready"}, 32'(f_ready), 32'(fr));
        chk({tag, ".d_pc"}, d_pc, epc);
        chk({tag, ".d_inst"}, d_inst, einst);
        chk({tag, ".d_bp"}, 32'(d_branch_predict), 32'(ebp));
        chk({tag, ".d_bt"}, d_branch_target, ebt);
    endtask

    task automatic drive(input logic e, fl, fv, dr, input logic [31:0] pc);
        en = e; flush = fl; f_valid = fv; d_ready = dr;
        f_pc = pc; f_inst = inst_of(pc); f_branch_predict = pc[2]; f_branch_target = pc + 32'h1000;
    endtask

    logic [31:0] rst_inst;

    initial begin
`ifdef FD_SKID_NOP_EN
        rst_inst = 32'h13;
`else
        rst_inst = 32'h0;
`endif
        // fill, full, drain, stale head
        add(1,0,1,0,32'h100, 1,1,32'h100);
        add(1,0,1,0,32'h104, 1,0,32'h100);
        add(1,0,1,0,32'h108, 1,0,32'h100);
        add(1,0,0,1,32'h0,   1,1,32'h104);
        add(1,0,0,1,32'h0,   0,1,32'h100);
        add(1,0,0,1,32'h0,   0,1,32'h100);
        // en=0 hold, then flush while disabled
        add(1,0,1,0,32'h200, 1,1,32'h200);
        for (int i = 0; i < 3; i++) add(0,0,1,1,32'h300, 1,1,32'h200);
        add(0,1,1,1,32'h300, 0,1,32'h200);
        // flush while full with a push offered
        add(1,0,1,0,32'h400, 1,1,32'h400);
        add(1,0,1,0,32'h404, 1,0,32'h400);
        add(1,1,1,1,32'h408, 0,1,32'h400);
        add(1,0,0,1,32'h0,   0,1,32'h400);
        // streaming 10 packets at one per cycle
        for (int k = 0; k < 10; k++) add(1,0,1,1,32'(4*k), 1,1,32'(4*k));
        add(1,0,0,1,32'h0,   0,1,32'h20);

        #12;
        chk("reset.d_valid", 32'(d_valid), 32'd0);
        chk("reset.f_ready", 32'(f_ready), 32'd1);
        chk("reset.d_pc", d_pc, 32'h0);
        chk("reset.d_inst", d_inst, rst_inst);
        chk("reset.d_bp", 32'(d_branch_predict), 32'd0);
        chk("reset.d_bt", d_branch_target, 32'h0);
        @(negedge CLK) nRST = 1'b1;

        foreach (tv[i]) begin
            @(negedge CLK) drive(tv[i].en, tv[i].fl, tv[i].fv, tv[i].dr, tv[i].pc);
            @(posedge CLK) #1;
            chk_out($sformatf("v%0d", i), tv[i].dv, tv[i].fr, tv[i].dpc);
        end

        // reset asserted mid-operation, between clock edges
        @(negedge CLK) drive(1,0,1,0,32'h500);
        @(posedge CLK) #1;
        chk_out("mid.pre", 1'b1, 1'b1, 32'h500);
        drive(0,0,0,0,32'h0);
        #1 nRST = 1'b0;
        #1;
        chk("mid.d_valid", 32'(d_valid), 32'd0);
        chk("mid.f_ready", 32'(f_ready), 32'd1);
        chk("mid.d_pc", d_pc, 32'h0);
        chk("mid.d_inst", d_inst, rst_inst);
        @(negedge CLK) nRST = 1'b1;
        @(negedge CLK) drive(1,0,1,0,32'h600);
        @(posedge CLK) #1;
        chk_out("post", 1'b1, 1'b1, 32'h600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
